// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default timing/geometry and a small address helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait states between request acceptance and the memory access (0..15)
    localparam int unsigned WAIT_CYC_DEFAULT = 2;
    // log2 of the number of 32-bit words held by the array
    localparam int unsigned DEPTH_W_DEFAULT  = 8;

    // Word accesses only: the two byte-offset bits must be zero
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port word storage: synchronous write, combinational read of the
// addressed word. Contents are never reset.
module mem_array #(
    parameter int unsigned DEPTH_W = mem_pkg::DEPTH_W_DEFAULT
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [2**DEPTH_W];

    // Write port: commit the word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one request at a time, inserts
// WAIT_CYC wait states, performs the word access and returns a one-cycle
// response strobe with load data, destination tag and alignment error.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEFAULT,
    parameter int unsigned DEPTH_W  = DEPTH_W_DEFAULT
) (
    input  logic        reloj,
    input  logic        resetMEM,
    input  logic        enableMEM,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] DIR_MEM,
    input  logic [31:0] DI_MEM,
    input  logic [4:0]  rd_i,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] DO_MEM,
    output logic [4:0]  rd_o,
    output logic        err_align
);

    state_t             state;
    logic [3:0]         cnt;
    logic [DEPTH_W-1:0] idx_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic [4:0]         rd_q;

    logic               accept;
    logic               aligned;
    logic               direct_access;
    logic               busy_access;
    logic               acc_we;
    logic               mem_we;
    logic [DEPTH_W-1:0] mem_idx;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    // Address bits above the word index are ignored so accesses wrap modulo depth
    logic               unused_addr_bits;
    assign unused_addr_bits = ^DIR_MEM[31:DEPTH_W+2];

    // Access decode: with no wait states the live request drives the array,
    // otherwise the captured fields are used when the counter expires in BUSY
    always_comb begin
        accept        = enableMEM && req_valid && (state == IDLE);
        aligned       = is_aligned(DIR_MEM);
        direct_access = accept && aligned && (WAIT_CYC == 0);
        busy_access   = enableMEM && (state == BUSY) && (cnt == '0);
        mem_idx       = idx_q;
        mem_wdata     = wdata_q;
        acc_we        = we_q;
        if (direct_access) begin
            mem_idx   = DIR_MEM[DEPTH_W+1:2];
            mem_wdata = DI_MEM;
            acc_we    = req_we;
        end
        mem_we = (direct_access || busy_access) && acc_we;
    end

    mem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_mem (
        .clk   (reloj),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge reloj or negedge resetMEM) begin
        if (!resetMEM) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            resp_valid <= 1'b0;
            DO_MEM     <= '0;
            rd_o       <= '0;
            err_align  <= 1'b0;
        end else if (enableMEM) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q     <= DIR_MEM[DEPTH_W+1:2];
                        wdata_q   <= DI_MEM;
                        we_q      <= req_we;
                        rd_q      <= rd_i;
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
                        if (!aligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            DO_MEM     <= '0;
                            rd_o       <= rd_i;
                            err_align  <= 1'b1;
                        end else if (WAIT_CYC == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            DO_MEM     <= req_we ? '0 : mem_rdata;
                            rd_o       <= rd_i;
                            err_align  <= 1'b0;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_CYC - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        DO_MEM     <= we_q ? '0 : mem_rdata;
                        rd_o       <= rd_q;
                        err_align  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    stall      <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    stall      <= 1'b0;
                end
            endcase
        end
    end

endmodule
